// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez memory arbiter: FSM encoding, port indices
// and default RAM address/data widths.
package simplez_pkg;

  localparam int unsigned AW_DEF = 9;
  localparam int unsigned DW_DEF = 12;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Port indices
  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/simplez_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for the Simplez memory arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface simplez_mem_arbiter_if
  import simplez_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/simplez_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
module simplez_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count grants, holding at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous Simplez RAM.
// Port 0 = CPU, port 1 = loader/debug. Grants are combinational, a locked
// grant keeps the RAM owned by that port until its lock drops.
// Define SIMPLEZ_ARB_RR_EN for round-robin contention; otherwise the loader
// always wins contention in IDLE.
module simplez_mem_arbiter
  import simplez_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  simplez_mem_arbiter_if.slave  bus,
  output logic [CW-1:0]         cnt0,
  output logic [CW-1:0]         cnt1
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_pick1;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

`ifdef SIMPLEZ_ARB_RR_EN
  logic r_rr_ptr;

  // Favour the port that was not granted most recently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= PORT_CPU;
    end else if (w_gnt0) begin
      r_rr_ptr <= PORT_LOADER;
    end else if (w_gnt1) begin
      r_rr_ptr <= PORT_CPU;
    end
  end

  assign w_pick1 = (r_rr_ptr == PORT_LOADER);
`else
  assign w_pick1 = 1'b1;
`endif

  // Grant decision and next ownership state
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_OWN0: begin
        w_gnt0 = bus.req0;
        if (!bus.lock0) w_state_nxt = ST_IDLE;
      end
      ST_OWN1: begin
        w_gnt1 = bus.req1;
        if (!bus.lock1) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (bus.req0 && bus.req1) begin
          w_gnt1 = w_pick1;
          w_gnt0 = !w_pick1;
        end else begin
          w_gnt0 = bus.req0;
          w_gnt1 = bus.req1;
        end
        if (w_gnt0 && bus.lock0) begin
          w_state_nxt = ST_OWN0;
        end else if (w_gnt1 && bus.lock1) begin
          w_state_nxt = ST_OWN1;
        end
      end
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Ownership state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM-side mux from the granted port, zero when idle
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    if (w_gnt0) begin
      w_addr  = bus.addr0;
      w_wdata = bus.wdata0;
    end else if (w_gnt1) begin
      w_addr  = bus.addr1;
      w_wdata = bus.wdata1;
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.mem_en    = w_gnt0 | w_gnt1;
  assign bus.mem_we    = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  // Read-return flags: one cycle after a granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
    end
  end

  // Hold the last returned word for each port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_rvalid0) r_rdata0 <= bus.mem_rdata;
      if (r_rvalid1) r_rdata1 <= bus.mem_rdata;
    end
  end

  // RAM data passes through in the return cycle; reset masks any in-flight read
  assign bus.rvalid0 = r_rvalid0 & ~rst;
  assign bus.rvalid1 = r_rvalid1 & ~rst;
  assign bus.rdata0  = rst ? '0 : (r_rvalid0 ? bus.mem_rdata : r_rdata0);
  assign bus.rdata1  = rst ? '0 : (r_rvalid1 ? bus.mem_rdata : r_rdata1);

  simplez_sat_counter #(.W(CW)) u_cnt0 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_gnt0),
    .o_cnt (cnt0)
  );

  simplez_sat_counter #(.W(CW)) u_cnt1 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_gnt1),
    .o_cnt (cnt1)
  );

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Bench for simplez_mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_simplez_mem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 12;
  localparam int unsigned CW = 16;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simplez_mem_arbiter_if #(.AW(AW), .DW(DW)) bif ();
  simplez_mem_arbiter_if #(.AW(AW), .DW(DW)) sif ();

  logic [CW-1:0] cnt0, cnt1;
  logic [3:0]    s_cnt0, s_cnt1;

  simplez_mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .cnt0(cnt0), .cnt1(cnt1)
  );

  simplez_mem_arbiter #(.AW(AW), .DW(DW), .CW(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sif.slave), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  // Synchronous RAM, one cycle read latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
      else            bif.mem_rdata     <= ram[bif.mem_addr];
    end
  end
  assign sif.mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_owner;
  int            m_fav;
  int            m_cnt0, m_cnt1;
  bit            m_pend0, m_pend1;
  logic [DW-1:0] m_pdat0, m_pdat1, m_hold0, m_hold1;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int            last_g;
  logic          o_g0, o_g1, o_rv0, o_rv1;
  logic [DW-1:0] o_rd0, o_rd1;
  logic [CW-1:0] o_c0, o_c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_fav   = 0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    m_pend0 = 1'b0;
    m_pend1 = 1'b0;
    m_hold0 = '0;
    m_hold1 = '0;
  endtask

  // One clock cycle: drive, predict, check at negedge, advance model
  task automatic tick(input bit r0, input bit w0, input bit l0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit r1, input bit w1, input bit l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit rs);
    int g;
    bit ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rst = rs;
    bif.req0 = r0; bif.we0 = w0; bif.lock0 = l0; bif.addr0 = a0; bif.wdata0 = d0;
    bif.req1 = r1; bif.we1 = w1; bif.lock1 = l1; bif.addr1 = a1; bif.wdata1 = d1;
    g = -1;
    if (rs)                g = -1;
    else if (m_owner == 0) g = r0 ? 0 : -1;
    else if (m_owner == 1) g = r1 ? 1 : -1;
    else if (r0 && r1) begin
`ifdef SIMPLEZ_ARB_RR_EN
      g = m_fav;
`else
      g = 1;
`endif
    end
    else if (r0)           g = 0;
    else if (r1)           g = 1;
    ewe = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin ewe = w0; ea = a0; ed = d0; end
    if (g == 1) begin ewe = w1; ea = a1; ed = d1; end

    @(negedge clk);
    chk("gnt0", 32'(bif.gnt0), 32'(g == 0));
    chk("gnt1", 32'(bif.gnt1), 32'(g == 1));
    chk("mem_en", 32'(bif.mem_en), 32'(g >= 0));
    chk("mem_we", 32'(bif.mem_we), 32'(ewe));
    chk("mem_addr", 32'(bif.mem_addr), 32'(ea));
    chk("mem_wdata", 32'(bif.mem_wdata), 32'(ed));
    chk("rvalid0", 32'(bif.rvalid0), 32'(rs ? 1'b0 : m_pend0));
    chk("rvalid1", 32'(bif.rvalid1), 32'(rs ? 1'b0 : m_pend1));
    chk("rdata0", 32'(bif.rdata0), 32'(rs ? '0 : (m_pend0 ? m_pdat0 : m_hold0)));
    chk("rdata1", 32'(bif.rdata1), 32'(rs ? '0 : (m_pend1 ? m_pdat1 : m_hold1)));
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    last_g = g;
    o_g0 = bif.gnt0; o_g1 = bif.gnt1; o_rv0 = bif.rvalid0; o_rv1 = bif.rvalid1;
    o_rd0 = bif.rdata0; o_rd1 = bif.rdata1; o_c0 = cnt0; o_c1 = cnt1;

    if (rs) begin
      model_reset();
    end else begin
      if (m_pend0) m_hold0 = m_pdat0;
      if (m_pend1) m_hold1 = m_pdat1;
      m_pend0 = (g == 0) && !w0;
      m_pend1 = (g == 1) && !w1;
      if (g == 0 && !w0) m_pdat0 = ref_mem[a0];
      if (g == 1 && !w1) m_pdat1 = ref_mem[a1];
      if (g == 0 && w0) ref_mem[a0] = d0;
      if (g == 1 && w1) ref_mem[a1] = d1;
      if (g == 0 && m_cnt0 < CMAX) m_cnt0++;
      if (g == 1 && m_cnt1 < CMAX) m_cnt1++;
      if (g >= 0) m_fav = 1 - g;
      if (m_owner < 0) begin
        if (g == 0 && l0)      m_owner = 0;
        else if (g == 1 && l1) m_owner = 1;
      end else if (m_owner == 0 && !l0) m_owner = -1;
      else if (m_owner == 1 && !l1)     m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rs);
    tick(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, rs);
  endtask

  int seq [4];
  bit r1first;
  bit p_r0, p_w0, p_l0, p_r1, p_w1, p_l1;
  logic [AW-1:0] p_a0, p_a1;
  logic [DW-1:0] p_d0, p_d1;

  initial begin
    rst = 1'b1;
    bif.req0 = 0; bif.we0 = 0; bif.lock0 = 0; bif.addr0 = '0; bif.wdata0 = '0;
    bif.req1 = 0; bif.we1 = 0; bif.lock1 = 0; bif.addr1 = '0; bif.wdata1 = '0;
    sif.req0 = 0; sif.we0 = 0; sif.lock0 = 0; sif.addr0 = '0; sif.wdata0 = '0;
    sif.req1 = 0; sif.we1 = 0; sif.lock1 = 0; sif.addr1 = '0; sif.wdata1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    idle(1);

    // Fill low RAM through the loader port
    for (int i = 0; i < 32; i++) begin
      tick(0, 0, 0, '0, '0, 1, 1, 0, AW'(i), (i == 5) ? 12'hABC : DW'($urandom), 0);
    end

    // Single read
    idle(1);
    tick(1, 0, 0, 9'h005, '0, 0, 0, 0, '0, '0, 0);
    chk("s1_gnt0", 32'(o_g0), 32'd1);
    idle(0);
    chk("s1_rvalid0", 32'(o_rv0), 32'd1);
    chk("s1_rdata0", 32'(o_rd0), 32'hABC);
    chk("s1_cnt0", 32'(o_c0), 32'd1);

    // Contention, both held for four grants
    idle(1);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, AW'(k), '0, 1, 0, 0, AW'(k + 8), '0, 0);
      seq[k] = last_g;
      chk("ct_gnt1", 32'(o_g1), 32'(seq[k] == 1));
    end
    idle(0);
`ifdef SIMPLEZ_ARB_RR_EN
    chk("ct_order", 32'({seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}), 32'h11);
    chk("ct_cnt0", 32'(o_c0), 32'd2);
    chk("ct_cnt1", 32'(o_c1), 32'd2);
    r1first = 1'b1;
`else
    chk("ct_order", 32'({seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}), 32'h55);
    chk("ct_cnt0", 32'(o_c0), 32'd0);
    chk("ct_cnt1", 32'(o_c1), 32'd4);
    r1first = 1'b0;
`endif

    // Lock: loader must stall until the unlocking grant has passed
    idle(1);
    tick(1, 0, 1, 9'h010, '0, r1first, 0, 0, 9'h001, '0, 0);
    chk("lk_g0_a", 32'(o_g0), 32'd1);
    chk("lk_g1_a", 32'(o_g1), 32'd0);
    tick(1, 1, 0, 9'h010, 12'h011, 1, 0, 0, 9'h001, '0, 0);
    chk("lk_g0_b", 32'(o_g0), 32'd1);
    chk("lk_g1_b", 32'(o_g1), 32'd0);
    tick(0, 0, 0, '0, '0, 1, 0, 0, 9'h001, '0, 0);
    chk("lk_g1_c", 32'(o_g1), 32'd1);
    idle(0);
    chk("lk_ram", 32'(ram[9'h010]), 32'h011);
    tick(1, 0, 0, 9'h010, '0, 0, 0, 0, '0, '0, 0);
    idle(0);
    chk("lk_rdata", 32'(o_rd0), 32'h011);

    // Reset right after a loader read grant
    tick(0, 0, 0, '0, '0, 1, 0, 0, 9'h003, '0, 0);
    chk("rm_gnt1", 32'(o_g1), 32'd1);
    idle(1);
    chk("rm_rv1_in_rst", 32'(o_rv1), 32'd0);
    idle(0);
    chk("rm_rv1_after", 32'(o_rv1), 32'd0);
    chk("rm_cnt1", 32'(o_c1), 32'd0);

    // Lock abandoned by reset: port 0 is served straight away afterwards
    tick(0, 0, 0, '0, '0, 1, 0, 1, 9'h004, '0, 0);
    tick(0, 0, 0, '0, '0, 1, 0, 1, 9'h004, '0, 1);
    tick(1, 0, 0, 9'h002, '0, 0, 0, 1, 9'h004, '0, 0);
    chk("rl_gnt0", 32'(o_g0), 32'd1);
    idle(0);

    // Random traffic
    p_r0 = 0; p_r1 = 0; p_w0 = 0; p_w1 = 0; p_l0 = 0; p_l1 = 0;
    p_a0 = '0; p_a1 = '0; p_d0 = '0; p_d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p_r0 && $urandom_range(0, 2) != 0) begin
        p_r0 = 1; p_w0 = 1'($urandom); p_l0 = ($urandom_range(0, 3) == 0);
        p_a0 = AW'($urandom_range(0, 31)); p_d0 = DW'($urandom);
      end
      if (!p_r1 && $urandom_range(0, 2) != 0) begin
        p_r1 = 1; p_w1 = 1'($urandom); p_l1 = ($urandom_range(0, 3) == 0);
        p_a1 = AW'($urandom_range(0, 31)); p_d1 = DW'($urandom);
      end
      tick(p_r0, p_w0, p_r0 & p_l0, p_a0, p_d0, p_r1, p_w1, p_r1 & p_l1, p_a1, p_d1,
           ($urandom_range(0, 63) == 0));
      if (last_g == 0) p_r0 = 0;
      if (last_g == 1) p_r1 = 0;
    end
    idle(0);

    // Saturation on the 4-bit counter instance
    sif.req0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("sat_gnt0", 32'(sif.gnt0), 32'd1);
      chk("sat_cnt0", 32'(s_cnt0), 32'((k < 15) ? k : 15));
      @(posedge clk);
      #1;
    end
    sif.req0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("sat_hold", 32'(s_cnt0), 32'd15);
    end
    chk("sat_cnt1", 32'(s_cnt1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simplez_mem_arbiter.md
SIMPLEZ_MEM_ARBITER -- requirements
Module: simplez_mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameters SHALL be: AW, default 9, RAM address width; DW, default 12, Simplez word width; CW, default 16, grant-counter width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0/req1  in  1  access request, port 0 = CPU, port 1 = loader/debug
- we0/we1  in  1  1 = write, 0 = read
- lock0/lock1  in  1  keep ownership after this grant
- addr0/addr1  in  AW  word address
- wdata0/wdata1  in  DW  write data
- gnt0/gnt1  out  1  combinational, access issued to RAM this cycle
- rvalid0/rvalid1  out  1  read data valid, registered
- rdata0/rdata1  out  DW  read data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, synchronous, 1-cycle latency
- cnt0/cnt1  out  CW  saturating grant counters

Function
REQ-004 A requester SHALL hold req, we, addr and wdata stable from assertion until the cycle its gnt is high; the arbiter SHALL consume the request in that cycle.
REQ-005 At most one of gnt0/gnt1 SHALL be high per cycle; mem_en SHALL equal gnt0|gnt1, and mem_we/addr/wdata SHALL be muxed from the granted port.
REQ-006 When no port is granted, mem_en and mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-007 A granted read SHALL produce rvalidN high for exactly one cycle, the cycle after gntN, with rdataN = mem_rdata; a write SHALL produce no rvalid.
REQ-008 rdataN SHALL hold its last value when rvalidN is low.
REQ-009 FSM states SHALL be IDLE, OWN0 and OWN1.
REQ-010 In IDLE with a single requester, that port SHALL be granted in the same cycle.
REQ-011 In IDLE with both requesting, the winner SHALL be chosen by the priority rule (REQ-017/018).
REQ-012 A grant to port N with lockN = 1 SHALL move the FSM to OWNN.
REQ-013 In OWNN only port N SHALL be granted, and the other port SHALL stall regardless of its req.
REQ-014 In OWNN, the FSM SHALL return to IDLE at the end of any cycle in which lockN = 0, whether or not port N was granted that cycle.
REQ-015 cntN SHALL increment on each gntN and saturate at 2^CW-1 without wrapping.
REQ-016 Back-to-back grants SHALL be possible every cycle with no idle cycle in between.

Reset
REQ-019 While rst is high: FSM = IDLE, gnt0/gnt1 = 0, mem_en = 0, rvalid0/rvalid1 = 0, rdata0/rdata1 = 0, cnt0/cnt1 = 0, round-robin pointer = 0 (port 0 favoured next).
REQ-020 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset.
REQ-021 A lock in progress SHALL be abandoned on reset.

Configuration
REQ-017 With `SIMPLEZ_ARB_RR_EN defined, IDLE contention SHALL be round-robin.
- The pointer SHALL favour the port not most recently granted.
- The pointer SHALL update on every grant.
REQ-018 Without `SIMPLEZ_ARB_RR_EN, IDLE contention SHALL use fixed priority with port 1 (loader) winning; no pointer register SHALL exist.

Structure
REQ-022 A shared package simplez_pkg SHALL hold the FSM state encoding, the port-index constants (CPU = 0, LOADER = 1) and the default widths AW = 9 and DW = 12.
REQ-023 The saturating counter SHALL be one sub-module, simplez_sat_counter, instantiated twice.
REQ-024 The target size SHALL be 120-400 lines of RTL.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single read: req0 alone, read addr 0x005 holding 0xABC -> gnt0 in cycle 0, rvalid0 = 1 with rdata0 = 0xABC in cycle 1, cnt0 = 1.
- Contention with RR defined: req0 = req1 = 1 held for 4 grants after reset -> grant order 0,1,0,1, cnt0 = cnt1 = 2.
- Contention without RR: same stimulus -> port 1 granted every cycle, gnt0 never high while req1 = 1.
- Lock: port 0 read with lock0 = 1 at 0x010, then write 0x011 at 0x010 with lock0 = 0, req1 asserted throughout -> gnt1 stays 0 until the cycle after the unlocking grant, and RAM[0x010] = 0x011.
- Reset mid-read: rst asserted the cycle after gnt1 for a read -> rvalid1 stays 0, cnt1 = 0, FSM = IDLE.
- Saturation with CW = 4: 20 grants to port 0 -> cnt0 = 15, held at 15.
